// File: rtl/double_threshold_hysteresis.sv
// Double-threshold classification and single-window hysteresis behind NMS.
// Two-stage valid/ready pipeline with per-frame threshold latch and edge statistics.
module double_threshold_hysteresis #(
    parameter int PIX_W = 11,
    parameter int CNT_W = 20
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [9*PIX_W-1:0] NMS_pixels,
    input  logic [17:0]        NMS_Direction_Data,
    input  logic               NMS_Pixels_in_valid,
    input  logic               in_first,
    input  logic               in_last,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   cfg_low_thr,
    input  logic [PIX_W-1:0]   cfg_high_thr,
    output logic [7:0]         edge_pixel,
    output logic [17:0]        edge_direction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [CNT_W-1:0]   stat_strong_cnt,
    output logic [CNT_W-1:0]   stat_edge_cnt,
    output logic               stat_valid
);

    logic             r_live;
    logic             w_adv;
    logic             w_acc;
    logic             w_ld;
    logic [PIX_W-1:0] w_cfg_low;
    logic [PIX_W-1:0] w_low;
    logic [PIX_W-1:0] w_high;
    logic [PIX_W-1:0] r_low;
    logic [PIX_W-1:0] r_high;
    logic [8:0]       w_strong;
    logic [PIX_W-1:0] w_ctr;
    logic             w_c_weak;

    logic             r_s1_valid;
    logic [8:0]       r_s1_strong;
    logic             r_s1_cweak;
    logic [17:0]      r_s1_dir;
    logic             r_s1_last;

    logic             w_nb_strong;
    logic             w_edge;
    logic             r_out_strong;

    logic             w_ohs;
    logic             w_sc_inc;
    logic             w_ec_inc;
    logic [CNT_W-1:0] r_strong_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] w_sc_nx;
    logic [CNT_W-1:0] w_ec_nx;

    // in_ready stays low for the first cycle after reset release
    assign w_adv    = r_live & (~out_valid | out_ready);
    assign in_ready = w_adv;
    assign w_acc    = NMS_Pixels_in_valid & w_adv;

    assign w_cfg_low = (cfg_low_thr > cfg_high_thr) ? cfg_high_thr : cfg_low_thr;
    assign w_ld      = w_acc & in_first;
    assign w_low     = w_ld ? w_cfg_low : r_low;
    assign w_high    = w_ld ? cfg_high_thr : r_high;

    for (genvar gi = 0; gi < 9; gi++) begin : g_cls
        logic [PIX_W-1:0] w_p;
        assign w_p          = NMS_pixels[gi*PIX_W +: PIX_W];
        assign w_strong[gi] = (|w_p) & (w_p >= w_high);
    end

    assign w_ctr    = NMS_pixels[4*PIX_W +: PIX_W];
    assign w_c_weak = (|w_ctr) & (w_ctr >= w_low) & (w_ctr < w_high);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_live <= 1'b0;
            r_low  <= '0;
            r_high <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_ld) begin
                r_low  <= w_cfg_low;
                r_high <= cfg_high_thr;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_s1_valid  <= 1'b0;
            r_s1_strong <= '0;
            r_s1_cweak  <= 1'b0;
            r_s1_dir    <= '0;
            r_s1_last   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid  <= w_acc;
            r_s1_strong <= w_acc ? w_strong : 9'd0;
            r_s1_cweak  <= w_acc & w_c_weak;
            r_s1_dir    <= w_acc ? NMS_Direction_Data : 18'd0;
            r_s1_last   <= w_acc & in_last;
        end
    end

    assign w_nb_strong = |{r_s1_strong[8:5], r_s1_strong[3:0]};
    assign w_edge      = r_s1_strong[4] | (r_s1_cweak & w_nb_strong);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_valid      <= 1'b0;
            edge_pixel     <= 8'h00;
            edge_direction <= '0;
            out_last       <= 1'b0;
            r_out_strong   <= 1'b0;
        end else if (w_adv) begin
            out_valid      <= r_s1_valid;
            edge_pixel     <= (r_s1_valid & w_edge) ? 8'hFF : 8'h00;
            edge_direction <= r_s1_dir;
            out_last       <= r_s1_valid & r_s1_last;
            r_out_strong   <= r_s1_valid & r_s1_strong[4];
        end
    end

    // Saturating counters; the last transfer of a frame is counted before the snapshot
    assign w_ohs    = out_valid & out_ready;
    assign w_sc_inc = r_out_strong & ~(&r_strong_cnt);
    assign w_ec_inc = edge_pixel[0] & ~(&r_edge_cnt);
    assign w_sc_nx  = r_strong_cnt + CNT_W'(w_sc_inc);
    assign w_ec_nx  = r_edge_cnt + CNT_W'(w_ec_inc);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_strong_cnt    <= '0;
            r_edge_cnt      <= '0;
            stat_strong_cnt <= '0;
            stat_edge_cnt   <= '0;
            stat_valid      <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (w_ohs) begin
                if (out_last) begin
                    stat_strong_cnt <= w_sc_nx;
                    stat_edge_cnt   <= w_ec_nx;
                    stat_valid      <= 1'b1;
                    r_strong_cnt    <= '0;
                    r_edge_cnt      <= '0;
                end else begin
                    r_strong_cnt <= w_sc_nx;
                    r_edge_cnt   <= w_ec_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_double_threshold_hysteresis.sv
// Directed bench for double_threshold_hysteresis with an output-order scoreboard.
module tb_double_threshold_hysteresis;

    localparam int PW = 11;
    localparam int CW = 20;

    logic            clk = 1'b0;
    logic            rstN;
    logic [9*PW-1:0] pix;
    logic [17:0]     dir;
    logic            vin;
    logic            first;
    logic            last;
    logic            in_ready;
    logic [PW-1:0]   lo;
    logic [PW-1:0]   hi;
    logic [7:0]      edge_pixel;
    logic [17:0]     edge_dir;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_last;
    logic [CW-1:0]   ss;
    logic [CW-1:0]   se;
    logic            sv;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stall_s = -100;
    int sv_cyc = 0;
    int stall_hits = 0;
    int sv0;

    typedef struct {
        logic [7:0]  e;
        logic [17:0] d;
        logic        l;
    } exp_t;
    exp_t q[$];

    double_threshold_hysteresis #(.PIX_W(PW), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rstN                (rstN),
        .NMS_pixels          (pix),
        .NMS_Direction_Data  (dir),
        .NMS_Pixels_in_valid (vin),
        .in_first            (first),
        .in_last             (last),
        .in_ready            (in_ready),
        .cfg_low_thr         (lo),
        .cfg_high_thr        (hi),
        .edge_pixel          (edge_pixel),
        .edge_direction      (edge_dir),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_last            (out_last),
        .stat_strong_cnt     (ss),
        .stat_edge_cnt       (se),
        .stat_valid          (sv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9*PW-1:0] mk(input int c, input int nb, input int p8);
        logic [9*PW-1:0] r;
        for (int i = 0; i < 9; i++)
            r[i*PW +: PW] = (i == 4) ? PW'(c) : (i == 8) ? PW'(p8) : PW'(nb);
        return r;
    endfunction

    // out_ready low for 3 cycles starting at cycle stall_s
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        out_ready = !(cyc >= stall_s && cyc < stall_s + 3);
    end

    initial forever begin
        @(negedge clk);
        if (sv) sv_cyc++;
        if (!out_ready && out_valid) begin
            stall_hits++;
            chk("stall_rdy", in_ready, 0);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("extra_out", 1, 0);
            else begin
                exp_t x;
                x = q.pop_front();
                chk("edge", edge_pixel, x.e);
                chk("dir", edge_dir, x.d);
                chk("last", out_last, x.l);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int c, input int nb, input int p8, input logic [17:0] d,
                        input logic f, input logic l, input logic [7:0] e);
        int   k;
        logic acc;
        exp_t x;
        pix   = mk(c, nb, p8);
        dir   = d;
        first = f;
        last  = l;
        vin   = 1'b1;
        k     = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            k++;
            if (k > 50) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        x.e = e;
        x.d = d;
        x.l = l;
        q.push_back(x);
        vin   = 1'b0;
        first = 1'b0;
        last  = 1'b0;
    endtask

    task automatic drain_stats(input string tag, input int s, input int e);
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            tick(1);
            k++;
        end
        chk({tag, "_drain"}, q.size(), 0);
        tick(2);
        chk({tag, "_svpulse"}, sv_cyc - sv0, 1);
        chk({tag, "_strong"}, ss, s);
        chk({tag, "_edges"}, se, e);
    endtask

    initial begin
        rstN  = 1'b0;
        vin   = 1'b0;
        pix   = '0;
        dir   = '0;
        first = 1'b0;
        last  = 1'b0;
        lo    = 11'd10;
        hi    = 11'd20;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_edge", edge_pixel, 0);
        chk("rst_ss", ss, 0);
        chk("rst_se", se, 0);
        chk("rst_sv", sv, 0);
        rstN = 1'b1;
        #1;
        chk("rdy_early", in_ready, 0);
        tick(1);
        chk("rdy_up", in_ready, 1);
        chk("idle_valid", out_valid, 0);

        // hysteresis frame, low=10 high=20
        sv0 = sv_cyc;
        send(25, 0, 0, 18'h1, 1, 0, 8'hFF);
        chk("lat_c1", out_valid, 0);
        tick(1);
        chk("lat_c2", out_valid, 1);
        chk("lat_edge", edge_pixel, 8'hFF);
        send(15, 0, 30, 18'h2, 0, 0, 8'hFF);
        send(15, 12, 12, 18'h3, 0, 0, 8'h00);
        send(5, 100, 100, 18'h4, 0, 0, 8'h00);
        send(20, 0, 0, 18'h5, 0, 1, 8'hFF);
        drain_stats("hyst", 2, 3);

        // backpressure stream
        sv0 = sv_cyc;
        stall_s = cyc + 3;
        send(30, 0, 0, 18'h11, 1, 0, 8'hFF);
        send(5, 0, 0, 18'h12, 0, 0, 8'h00);
        send(15, 0, 25, 18'h13, 0, 0, 8'hFF);
        send(12, 12, 12, 18'h14, 0, 0, 8'h00);
        send(21, 0, 0, 18'h15, 0, 0, 8'hFF);
        send(19, 0, 20, 18'h16, 0, 1, 8'hFF);
        drain_stats("bp", 2, 4);
        chk("stall_seen", stall_hits > 0, 1);

        // statistics frame: 3 strong, 2 weak-promoted
        sv0 = sv_cyc;
        send(30, 0, 0, 18'h21, 1, 0, 8'hFF);
        send(15, 0, 40, 18'h22, 0, 0, 8'hFF);
        send(20, 0, 0, 18'h23, 0, 0, 8'hFF);
        send(3, 0, 0, 18'h24, 0, 0, 8'h00);
        send(12, 12, 12, 18'h25, 0, 0, 8'h00);
        send(11, 25, 25, 18'h26, 0, 0, 8'hFF);
        send(0, 50, 50, 18'h27, 0, 0, 8'h00);
        send(100, 0, 0, 18'h28, 0, 1, 8'hFF);
        drain_stats("stat", 3, 5);

        // clamp and mid-frame threshold change
        sv0 = sv_cyc;
        lo = 11'd50;
        hi = 11'd40;
        send(45, 0, 0, 18'h31, 1, 0, 8'hFF);
        lo = 11'd10;
        hi = 11'd100;
        send(45, 0, 0, 18'h32, 0, 0, 8'hFF);
        send(39, 0, 0, 18'h33, 0, 0, 8'h00);
        send(42, 0, 0, 18'h34, 0, 1, 8'hFF);
        drain_stats("clamp", 3, 3);

        // single-window frame, zero centre with low=0
        sv0 = sv_cyc;
        lo = 11'd0;
        hi = 11'd100;
        send(0, 200, 200, 18'h41, 1, 1, 8'h00);
        drain_stats("single", 0, 0);

        // async reset with two windows in flight
        lo = 11'd10;
        hi = 11'd20;
        sv0 = sv_cyc;
        send(30, 0, 0, 18'h51, 1, 0, 8'hFF);
        send(30, 0, 0, 18'h52, 0, 0, 8'hFF);
        chk("pre_rst_valid", out_valid, 1);
        #1;
        rstN = 1'b0;
        #1;
        chk("async_drop", out_valid, 0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        tick(2);
        chk("rst_no_sv", sv_cyc - sv0, 0);
        chk("rst_ss_clr", ss, 0);
        sv0 = sv_cyc;
        send(30, 0, 0, 18'h61, 1, 0, 8'hFF);
        send(5, 0, 0, 18'h62, 0, 1, 8'h00);
        drain_stats("post_rst", 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
